bht_access_scheduler: RTL and testbench
=======================================

// Module: bht_access_scheduler
// PURPOSE
//  Owns the single R/W port of the 1024x2b branch history table and shares it between fetch-stage
//  prediction reads and EX-stage counter updates. Buffers resolved updates in a small FIFO and
//  computes the 2-bit saturating next value. Forwards pending updates to reads and keeps an 8-bit
//  global history register. Clears the table after reset. Sits between IF/EX pipeline control and the BHT array.
// PARAMETERS
//  IDX_W     10   BHT index width (table depth = 2**IDX_W)
//  FIFO_D    4    update FIFO depth (power of 2, >=2)
//  GHR_W     8    global history width (<= IDX_W)
// PORTS
//  clk          in   1       clock, all state on rising edge
//  rst_n        in   1       asynchronous active-low reset
//  fetch_req    in   1       IF requests a prediction for fetch_pc
//  fetch_pc     in   32      PC of the fetched branch
//  fetch_gnt    out  1       read issued to BHT this cycle
//  flush        in   1       pipeline flush; kills the in-flight prediction
//  pred_valid   out  1       prediction available (1 cycle after fetch_gnt)
//  pred_ctr     out  2       predicted counter value
//  pred_taken   out  1       pred_ctr[1]
//  upd_valid    in   1       EX resolved a branch
//  upd_pc       in   32      PC of resolved branch
//  upd_old_ctr  in   2       counter value used at prediction time
//  upd_taken    in   1       actual outcome
//  upd_ready    out  1       FIFO can accept; push = upd_valid & upd_ready
//  bht_en       out  1       BHT port enable
//  bht_we       out  1       1 = write, 0 = read
//  bht_addr     out  IDX_W   BHT index
//  bht_wdata    out  2       write data
//  bht_rdata    in   2       synchronous read data, valid cycle after read
//  ghr          out  GHR_W   global history register
//  init_busy    out  1       table clear in progress
// BEHAVIOUR
//  Reset: state=INIT, init counter=0, FIFO empty, ghr=0, fetch_gnt=pred_valid=0, pred_ctr=0,
//   upd_ready=0, bht_en=bht_we=0, bht_wdata=0, init_busy=1.
//  FSM INIT: write 2'b00 to index 0..2**IDX_W-1, one per cycle; fetch_gnt=0, upd_ready=0.
//   After the last index -> RUN. Reset asserted mid-INIT restarts from index 0.
//  RUN: priority fetch read > FIFO head write. fetch_gnt=fetch_req. If no fetch_req and FIFO
//   non-empty, write head (bht_we=1) and pop. FIFO count==FIFO_D -> DRAIN.
//  DRAIN: write head each cycle, fetch_gnt=0; return to RUN when count <= FIFO_D/2.
//  Exactly one BHT access per cycle; bht_en=0 when idle.
//  Push: new = taken ? min(old+1,3) : max(old-1,0); store {index,new}. ghr <= {ghr[GHR_W-2:0],upd_taken}.
//   upd_ready = (state!=INIT) & (count<FIFO_D). Push and pop in same cycle allowed (count unchanged).
//  Index: idx(pc) = pc[IDX_W:1]; write index is captured at push time.
//  Read: pred_valid=1 one cycle after fetch_gnt unless flush is high in that cycle or the one before.
//   pred_ctr = youngest FIFO entry whose index matches the read index, captured at grant.
//   An entry pushed in the grant cycle also counts. Otherwise pred_ctr = bht_rdata.
//  No valid read crosses DRAIN or INIT entry. Unused upper ghr bits zero-extend when XORed.
// CONFIGURATION
//  BHT_GSHARE_EN defined: read index = pc[IDX_W:1] ^ zero-extended ghr (current value).
//   Update index = upd_pc[IDX_W:1] ^ ghr before that push's shift. Forwarding compares the XORed indices.
//  Undefined: both indices = pc[IDX_W:1]; ghr is still maintained and output.
// TESTING
//  Reset then idle -> init_busy=1 for 1024 cycles, bht_addr 0..1023 with we=1/wdata=0, then RUN, upd_ready=1.
//  upd pc=0x40 old=2'b11 taken=1 -> stored 2'b11; old=2'b00 taken=0 -> 2'b00; old=2'b01 taken=1 -> 2'b10.
//  Push pc=0x40 new=2'b10, fetch_req pc=0x40 same cycle -> next cycle pred_valid=1, pred_ctr=2'b10 (forwarded).
//  fetch_req held high, 4 pushes -> DRAIN: fetch_gnt=0, 2 writes, back to RUN, fetch_gnt=1.
//  fetch_gnt at t, flush at t+1 -> pred_valid=0 at t+1; ghr after taken,not,taken pushes = 8'b00000101.
//  BHT_GSHARE_EN, ghr=8'h05, fetch_pc=0x40 -> bht_addr = 10'h020 ^ 10'h005 = 10'h025.

Source files
------------

// File: rtl/bht_access_scheduler.sv
// Arbitrates the single BHT R/W port between fetch prediction reads and buffered EX counter updates,
// clears the table after reset and keeps a global history register. Optional gshare indexing: BHT_GSHARE_EN.
module bht_access_scheduler #(
  parameter int unsigned IDX_W  = 10,
  parameter int unsigned FIFO_D = 4,
  parameter int unsigned GHR_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fetch_req,
  input  logic [31:0]      fetch_pc,
  output logic             fetch_gnt,
  input  logic             flush,
  output logic             pred_valid,
  output logic [1:0]       pred_ctr,
  output logic             pred_taken,
  input  logic             upd_valid,
  input  logic [31:0]      upd_pc,
  input  logic [1:0]       upd_old_ctr,
  input  logic             upd_taken,
  output logic             upd_ready,
  output logic             bht_en,
  output logic             bht_we,
  output logic [IDX_W-1:0] bht_addr,
  output logic [1:0]       bht_wdata,
  input  logic [1:0]       bht_rdata,
  output logic [GHR_W-1:0] ghr,
  output logic             init_busy
);

  localparam int unsigned PTR_W = $clog2(FIFO_D);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(FIFO_D);
  localparam logic [CNT_W-1:0] HALF = CNT_W'(FIFO_D / 2);

  typedef enum logic [1:0] {S_INIT, S_RUN, S_DRAIN} state_t;

  state_t           state, state_next;
  logic [IDX_W-1:0] init_cnt;
  logic [IDX_W-1:0] fifo_idx [FIFO_D];
  logic [1:0]       fifo_ctr [FIFO_D];
  logic [PTR_W-1:0] rd_ptr, wr_ptr, scan_ptr;
  logic [CNT_W-1:0] count, count_next;
  logic             push, pop, en_c, we_c;
  logic             gnt_q, flush_q, fwd_hit, fwd_hit_q;
  logic [1:0]       fwd_ctr, fwd_ctr_q, upd_new;
  logic [IDX_W-1:0] rd_idx, upd_idx;
  logic             unused_pc_bits;

  assign unused_pc_bits = ^{fetch_pc[31:IDX_W+1], fetch_pc[0], upd_pc[31:IDX_W+1], upd_pc[0]};

`ifdef BHT_GSHARE_EN
  logic [IDX_W-1:0] ghr_ext;

  // Both indices hash with the history as it stands before this cycle's push shifts it.
  always_comb begin
    ghr_ext = '0;
    ghr_ext[GHR_W-1:0] = ghr;
    rd_idx  = fetch_pc[IDX_W:1] ^ ghr_ext;
    upd_idx = upd_pc[IDX_W:1] ^ ghr_ext;
  end
`else
  always_comb begin
    rd_idx  = fetch_pc[IDX_W:1];
    upd_idx = upd_pc[IDX_W:1];
  end
`endif

  always_comb begin
    if (upd_taken) upd_new = (upd_old_ctr == 2'b11) ? 2'b11 : upd_old_ctr + 2'b01;
    else           upd_new = (upd_old_ctr == 2'b00) ? 2'b00 : upd_old_ctr - 2'b01;
  end

  always_comb begin
    state_next = state;
    fetch_gnt  = 1'b0;
    pop        = 1'b0;
    en_c       = 1'b0;
    we_c       = 1'b0;
    bht_addr   = '0;
    bht_wdata  = '0;
    upd_ready  = (state != S_INIT) && (count < FULL);
    push       = upd_valid && upd_ready;
    case (state)
      S_INIT: begin
        en_c     = 1'b1;
        we_c     = 1'b1;
        bht_addr = init_cnt;
        if (init_cnt == '1) state_next = S_RUN;
      end
      S_RUN: begin
        if (fetch_req) begin
          fetch_gnt = 1'b1;
          en_c      = 1'b1;
          bht_addr  = rd_idx;
        end else if (count != '0) begin
          en_c      = 1'b1;
          we_c      = 1'b1;
          bht_addr  = fifo_idx[rd_ptr];
          bht_wdata = fifo_ctr[rd_ptr];
          pop       = 1'b1;
        end
      end
      S_DRAIN: begin
        if (count != '0) begin
          en_c      = 1'b1;
          we_c      = 1'b1;
          bht_addr  = fifo_idx[rd_ptr];
          bht_wdata = fifo_ctr[rd_ptr];
          pop       = 1'b1;
        end
      end
      default: state_next = S_INIT;
    endcase
    count_next = count + CNT_W'(push) - CNT_W'(pop);
    if (state == S_RUN && count_next == FULL) state_next = S_DRAIN;
    if (state == S_DRAIN && count_next <= HALF) state_next = S_RUN;
  end

  // Youngest matching entry wins; an update pushed alongside the grant is younger than all stored ones.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_ctr  = '0;
    scan_ptr = rd_ptr;
    for (int unsigned i = 0; i < FIFO_D; i++) begin
      scan_ptr = rd_ptr + PTR_W'(i);
      if ((CNT_W'(i) < count) && (fifo_idx[scan_ptr] == rd_idx)) begin
        fwd_hit = 1'b1;
        fwd_ctr = fifo_ctr[scan_ptr];
      end
    end
    if (push && (upd_idx == rd_idx)) begin
      fwd_hit = 1'b1;
      fwd_ctr = upd_new;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_INIT;
      init_cnt  <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      ghr       <= '0;
      gnt_q     <= 1'b0;
      flush_q   <= 1'b0;
      fwd_hit_q <= 1'b0;
      fwd_ctr_q <= '0;
    end else begin
      state <= state_next;
      if (state == S_INIT) init_cnt <= init_cnt + IDX_W'(1);
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
        ghr    <= {ghr[GHR_W-2:0], upd_taken};
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count     <= count_next;
      gnt_q     <= fetch_gnt;
      flush_q   <= flush;
      fwd_hit_q <= fwd_hit;
      fwd_ctr_q <= fwd_ctr;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_idx[wr_ptr] <= upd_idx;
      fifo_ctr[wr_ptr] <= upd_new;
    end
  end

  // Port strobes are held off while reset is asserted even though the FSM already sits in INIT.
  assign bht_en     = en_c & rst_n;
  assign bht_we     = we_c & rst_n;
  assign init_busy  = (state == S_INIT);
  assign pred_valid = gnt_q & ~flush & ~flush_q & (state == S_RUN);
  assign pred_ctr   = gnt_q ? (fwd_hit_q ? fwd_ctr_q : bht_rdata) : 2'b00;
  assign pred_taken = pred_ctr[1];

endmodule

// File: tb/tb_bht_access_scheduler.sv
// Scoreboard bench for bht_access_scheduler: a behavioural BHT array, a latest-value table model,
// and queues of expected writes and predictions compared as the DUT produces them.
module tb_bht_access_scheduler;
  localparam int IDX_W  = 10;
  localparam int FIFO_D = 4;
  localparam int GHR_W  = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_req = 1'b0, flush = 1'b0, upd_valid = 1'b0, upd_taken = 1'b0;
  logic [31:0] fetch_pc = '0, upd_pc = '0;
  logic [1:0]  upd_old_ctr = '0;
  logic        fetch_gnt, pred_valid, pred_taken, upd_ready, bht_en, bht_we, init_busy;
  logic [1:0]  pred_ctr, bht_wdata, bht_rdata;
  logic [9:0]  bht_addr;
  logic [7:0]  ghr;

  always #5 clk = ~clk;

  bht_access_scheduler #(.IDX_W(IDX_W), .FIFO_D(FIFO_D), .GHR_W(GHR_W)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_req(fetch_req), .fetch_pc(fetch_pc), .fetch_gnt(fetch_gnt),
    .flush(flush), .pred_valid(pred_valid), .pred_ctr(pred_ctr), .pred_taken(pred_taken),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_old_ctr(upd_old_ctr), .upd_taken(upd_taken),
    .upd_ready(upd_ready), .bht_en(bht_en), .bht_we(bht_we), .bht_addr(bht_addr),
    .bht_wdata(bht_wdata), .bht_rdata(bht_rdata), .ghr(ghr), .init_busy(init_busy)
  );

  // Array stores value^3 so an unwritten entry reads as 2'b11 until the clear reaches it.
  bit   [1:0] mem [1024];
  logic [1:0] rdata_r;
  assign bht_rdata = rdata_r;
  always @(posedge clk) begin
    if (bht_en === 1'b1) begin
      if (bht_we) mem[bht_addr] <= bht_wdata ^ 2'b11;
      else        rdata_r <= mem[bht_addr] ^ 2'b11;
    end
  end

  int unsigned n_checks = 0, n_errors = 0;
  int          mstate, minit, mcnt;
  int unsigned stall_cnt;
  logic [7:0]  mghr;
  logic [1:0]  mtbl [1024];
  logic [11:0] wr_q [$];
  logic [1:0]  pred_q [$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mstate = 0; minit = 0; mcnt = 0; mghr = '0;
    wr_q.delete();
    pred_q.delete();
    for (int i = 0; i < 1024; i++) mtbl[i] = 2'b00;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; fetch_req = 1'b0; flush = 1'b0; upd_valid = 1'b0;
    model_reset();
    @(negedge clk); #1;
    check("rst_init_busy", init_busy, 1);
    check("rst_upd_ready", upd_ready, 0);
    check("rst_fetch_gnt", fetch_gnt, 0);
    check("rst_pred_valid", pred_valid, 0);
    check("rst_pred_ctr", pred_ctr, 0);
    check("rst_ghr", ghr, 0);
    check("rst_bht_en", bht_en, 0);
    check("rst_bht_we", bht_we, 0);
    check("rst_bht_wdata", bht_wdata, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock: called at a negedge with inputs already driven; returns at the next negedge.
  task automatic cyc();
    logic [9:0]  ridx, uidx, gx, exp_addr;
    logic [1:0]  unew, exp_wd, pexp;
    logic        push, epv, exp_en, exp_we, do_pop;
    logic [11:0] head;
    int          v;
    #1;
    gx = {2'b00, mghr};
`ifdef BHT_GSHARE_EN
    ridx = fetch_pc[10:1] ^ gx;
    uidx = upd_pc[10:1] ^ gx;
`else
    ridx = fetch_pc[10:1];
    uidx = upd_pc[10:1];
`endif
    v = int'(upd_old_ctr) + (upd_taken ? 1 : -1);
    if (v < 0) v = 0;
    if (v > 3) v = 3;
    unew = v[1:0];

    epv = (pred_q.size() != 0) && !flush && (mstate == 1);
    check("pred_valid", pred_valid, epv);
    if (pred_q.size() != 0) begin
      pexp = pred_q.pop_front();
      if (epv) begin
        check("pred_ctr", pred_ctr, pexp);
        check("pred_taken", pred_taken, pexp[1]);
      end
    end

    check("init_busy", init_busy, mstate == 0);
    check("upd_ready", upd_ready, (mstate != 0) && (mcnt < FIFO_D));
    check("fetch_gnt", fetch_gnt, (mstate == 1) && fetch_req);
    check("ghr", ghr, mghr);
    if (fetch_req && !fetch_gnt && mstate != 0) stall_cnt++;

    push = upd_valid && (mstate != 0) && (mcnt < FIFO_D);
    do_pop = 1'b0; exp_en = 1'b0; exp_we = 1'b0; exp_addr = '0; exp_wd = '0;
    if (mstate == 0) begin
      exp_en = 1'b1; exp_we = 1'b1; exp_addr = 10'(minit);
    end else if (mstate == 1 && fetch_req) begin
      exp_en = 1'b1; exp_addr = ridx;
    end else if (mcnt != 0) begin
      head = wr_q[0];
      exp_en = 1'b1; exp_we = 1'b1; exp_addr = head[11:2]; exp_wd = head[1:0]; do_pop = 1'b1;
    end
    check("bht_en", bht_en, exp_en);
    check("bht_we", bht_we, exp_we);
    if (exp_en) check("bht_addr", bht_addr, exp_addr);
    if (exp_we) check("bht_wdata", bht_wdata, exp_wd);

    if (push) begin
      mtbl[uidx] = unew;
      wr_q.push_back({uidx, unew});
      mghr = {mghr[6:0], upd_taken};
    end
    if (mstate == 1 && fetch_req && !flush) pred_q.push_back(mtbl[ridx]);
    if (do_pop) void'(wr_q.pop_front());
    mcnt = mcnt + int'(push) - int'(do_pop);
    case (mstate)
      0: begin
        if (minit == 1023) mstate = 1;
        minit++;
      end
      1: if (mcnt == FIFO_D) mstate = 2;
      2: if (mcnt <= FIFO_D / 2) mstate = 1;
      default: mstate = 0;
    endcase
    @(negedge clk);
  endtask

  task automatic upd(input logic [31:0] pc, input logic [1:0] old, input logic taken);
    upd_valid = 1'b1; upd_pc = pc; upd_old_ctr = old; upd_taken = taken;
    cyc();
    upd_valid = 1'b0;
  endtask

  initial begin
    logic [9:0] sidx;
    logic [31:0] pcs [4];
    pcs[0] = 32'h40; pcs[1] = 32'h44; pcs[2] = 32'h48; pcs[3] = 32'h100;
    stall_cnt = 0;

    do_reset();
    repeat (40) cyc();
    do_reset();
    repeat (1024) cyc();
    check("run_init_busy", init_busy, 0);
    check("run_upd_ready", upd_ready, 1);

    upd(32'h40, 2'b11, 1'b1);
    upd(32'h40, 2'b00, 1'b0);
    upd(32'h40, 2'b01, 1'b1);
    cyc();
    check("ghr_101", ghr, 8'h05);
`ifdef BHT_GSHARE_EN
    sidx = 10'h022;
`else
    sidx = 10'h020;
`endif
    check("stored_ctr", mem[sidx] ^ 2'b11, 2'b10);

    fetch_req = 1'b1; fetch_pc = 32'h40;
    #1;
`ifdef BHT_GSHARE_EN
    check("gshare_addr", bht_addr, 10'h025);
`else
    check("plain_addr", bht_addr, 10'h020);
`endif
    cyc();
    fetch_req = 1'b0;

    upd(32'h40, 2'b00, 1'b0);
    cyc();
    fetch_req = 1'b1; fetch_pc = 32'h40;
    upd(32'h40, 2'b01, 1'b1);
    fetch_req = 1'b0;
    #1;
    check("fwd_valid", pred_valid, 1);
    check("fwd_ctr", pred_ctr, 2'b10);
    repeat (3) cyc();

    stall_cnt = 0;
    fetch_req = 1'b1; fetch_pc = 32'h48;
    for (int i = 0; i < 4; i++) upd(32'h100 + 32'(4 * i), 2'(i), 1'b1);
    repeat (4) cyc();
    check("drain_stalls", stall_cnt, 2);
    fetch_req = 1'b0;
    repeat (4) cyc();

    fetch_req = 1'b1; fetch_pc = 32'h44;
    cyc();
    fetch_req = 1'b0; flush = 1'b1;
    #1;
    check("flush_kill", pred_valid, 0);
    cyc();
    flush = 1'b0;

    for (int n = 0; n < 400; n++) begin
      fetch_req   = ($urandom_range(0, 2) != 0);
      fetch_pc    = pcs[$urandom_range(0, 3)];
      flush       = ($urandom_range(0, 7) == 0);
      upd_valid   = ($urandom_range(0, 1) != 0);
      upd_pc      = pcs[$urandom_range(0, 3)];
      upd_old_ctr = 2'($urandom_range(0, 3));
      upd_taken   = ($urandom_range(0, 1) != 0);
      cyc();
    end
    fetch_req = 1'b0; flush = 1'b0; upd_valid = 1'b0;
    repeat (8) cyc();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
